// File: rtl/regfile_context_sequencer_if.sv
// -----------------------------------------------------------------------------
// regfile_context_sequencer_if
//
// Bus bundle between the context sequencer and the resources it moves data
// between: the register-file read/write ports and the memory handshake.
//
//   rf_rd_addr / rf_rd_data              register-file read port (data is
//                                        combinational from the address)
//   rf_wr_en / rf_wr_addr / rf_wr_data   register-file write port
//   mem_req / mem_we / mem_addr /
//   mem_wdata / mem_rdata / mem_ack      memory request/acknowledge handshake
//
// master : the sequencer (drives addresses, write data, requests)
// slave  : register file + memory (drive read data and acknowledge)
// -----------------------------------------------------------------------------
interface regfile_context_sequencer_if;
    logic [4:0]  rf_rd_addr;
    logic [31:0] rf_rd_data;
    logic        rf_wr_en;
    logic [4:0]  rf_wr_addr;
    logic [31:0] rf_wr_data;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport master (
        output rf_rd_addr,
        input  rf_rd_data,
        output rf_wr_en,
        output rf_wr_addr,
        output rf_wr_data,
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ack
    );

    modport slave (
        input  rf_rd_addr,
        output rf_rd_data,
        input  rf_wr_en,
        input  rf_wr_addr,
        input  rf_wr_data,
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_ack
    );
endinterface

// File: rtl/regfile_context_sequencer.sv
// -----------------------------------------------------------------------------
// regfile_context_sequencer
//
// Moves a contiguous range of general-purpose registers (FIRST_REG..LAST_REG,
// never x0) between the register file and memory: save (regs -> save area),
// restore (restore area -> regs) or swap (save, then restore).
//
// Ports
//   clk           single clock, rising edge
//   reset         asynchronous, active-low; clears state and every output
//   ctx_req       start request, only looked at while idle
//   ctx_op        01 save, 10 restore, 11 swap, 00 no-op
//   save_base     word-aligned base of the save area (latched on accept)
//   restore_base  word-aligned base of the restore area (latched on accept)
//   bus           register-file and memory ports (master side)
//   stall, busy   high in every state except IDLE
//   done          one-cycle pulse in the final cycle of an operation
//
// Build option
//   CTX_SWAP_EN   when defined, ctx_op=11 performs a swap; when undefined,
//                 ctx_op=11 is ignored and the save-to-restore path is absent.
//
// All outputs are registered: next-cycle values are derived from the next
// state in the combinational block, so they line up with the state they
// belong to.
// -----------------------------------------------------------------------------
module regfile_context_sequencer #(
    parameter int FIRST_REG = 1,
    parameter int LAST_REG  = 31
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               ctx_req,
    input  logic [1:0]                         ctx_op,
    input  logic [31:0]                        save_base,
    input  logic [31:0]                        restore_base,
    regfile_context_sequencer_if.master        bus,
    output logic                               stall,
    output logic                               busy,
    output logic                               done
);

    // x0 is hard-wired zero, so the range always starts at 1 or above.
    localparam logic [4:0] FIRST_IDX = (FIRST_REG == 0) ? 5'd1 : 5'(FIRST_REG);
    localparam logic [4:0] LAST_IDX  = 5'(LAST_REG);

    typedef enum logic [2:0] {
        IDLE,
        SAVE_RD,
        SAVE_MEM,
        REST_MEM,
        REST_WR,
        DONE
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  idx_q, idx_d;
    logic [31:0] save_base_q, save_base_d;
    logic [31:0] restore_base_q, restore_base_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [4:0]  rf_rd_addr_q, rf_rd_addr_d;
    logic        rf_wr_en_q, rf_wr_en_d;
    logic [4:0]  rf_wr_addr_q, rf_wr_addr_d;
    logic [31:0] rf_wr_data_q, rf_wr_data_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
`ifdef CTX_SWAP_EN
    logic        swap_q, swap_d;
`endif
    logic        accept;
    logic [31:0] word_offset;

    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        save_base_d    = save_base_q;
        restore_base_d = restore_base_q;
        mem_wdata_d    = mem_wdata_q;
        rf_wr_data_d   = rf_wr_data_q;
`ifdef CTX_SWAP_EN
        swap_d         = swap_q;
        accept         = ctx_req && (ctx_op != 2'b00);
`else
        // Without swap support, op 11 is indistinguishable from a no-op.
        accept         = ctx_req && ((ctx_op == 2'b01) || (ctx_op == 2'b10));
`endif

        case (state_q)
            IDLE: begin
                if (accept) begin
                    save_base_d    = save_base;
                    restore_base_d = restore_base;
                    idx_d          = FIRST_IDX;
`ifdef CTX_SWAP_EN
                    swap_d         = (ctx_op == 2'b11);
`endif
                    state_d        = (ctx_op == 2'b10) ? REST_MEM : SAVE_RD;
                end
            end
            SAVE_RD: begin
                mem_wdata_d = bus.rf_rd_data;
                state_d     = SAVE_MEM;
            end
            SAVE_MEM: begin
                if (bus.mem_ack) begin
                    if (idx_q < LAST_IDX) begin
                        idx_d   = idx_q + 5'd1;
                        state_d = SAVE_RD;
                    end else begin
`ifdef CTX_SWAP_EN
                        if (swap_q) begin
                            idx_d   = FIRST_IDX;
                            state_d = REST_MEM;
                        end else begin
                            state_d = DONE;
                        end
`else
                        state_d = DONE;
`endif
                    end
                end
            end
            REST_MEM: begin
                if (bus.mem_ack) begin
                    rf_wr_data_d = bus.mem_rdata;
                    state_d      = REST_WR;
                end
            end
            REST_WR: begin
                if (idx_q < LAST_IDX) begin
                    idx_d   = idx_q + 5'd1;
                    state_d = REST_MEM;
                end else begin
                    state_d = DONE;
                end
            end
            DONE: begin
                idx_d   = FIRST_IDX;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Registered outputs follow the state being entered. While waiting for
        // an ack the state and index do not move, so address/request stay put.
        word_offset  = {25'd0, idx_d, 2'b00};
        mem_req_d    = (state_d == SAVE_MEM) || (state_d == REST_MEM);
        mem_we_d     = (state_d == SAVE_MEM);
        mem_addr_d   = (state_d == SAVE_MEM) ? save_base_d + word_offset :
                       (state_d == REST_MEM) ? restore_base_d + word_offset : 32'd0;
        rf_rd_addr_d = (state_d == SAVE_RD) ? idx_d : 5'd0;
        rf_wr_en_d   = (state_d == REST_WR);
        rf_wr_addr_d = (state_d == REST_WR) ? idx_d : 5'd0;
        busy_d       = (state_d != IDLE);
        done_d       = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            idx_q          <= FIRST_IDX;
            save_base_q    <= 32'd0;
            restore_base_q <= 32'd0;
            mem_req_q      <= 1'b0;
            mem_we_q       <= 1'b0;
            mem_addr_q     <= 32'd0;
            mem_wdata_q    <= 32'd0;
            rf_rd_addr_q   <= 5'd0;
            rf_wr_en_q     <= 1'b0;
            rf_wr_addr_q   <= 5'd0;
            rf_wr_data_q   <= 32'd0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
`ifdef CTX_SWAP_EN
            swap_q         <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            save_base_q    <= save_base_d;
            restore_base_q <= restore_base_d;
            mem_req_q      <= mem_req_d;
            mem_we_q       <= mem_we_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
            rf_rd_addr_q   <= rf_rd_addr_d;
            rf_wr_en_q     <= rf_wr_en_d;
            rf_wr_addr_q   <= rf_wr_addr_d;
            rf_wr_data_q   <= rf_wr_data_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
`ifdef CTX_SWAP_EN
            swap_q         <= swap_d;
`endif
        end
    end

    assign bus.mem_req    = mem_req_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.rf_rd_addr = rf_rd_addr_q;
    assign bus.rf_wr_en   = rf_wr_en_q;
    assign bus.rf_wr_addr = rf_wr_addr_q;
    assign bus.rf_wr_data = rf_wr_data_q;
    assign busy           = busy_q;
    assign stall          = busy_q;
    assign done           = done_q;

endmodule

// File: tb/tb_regfile_context_sequencer.sv
// -----------------------------------------------------------------------------
// tb_regfile_context_sequencer
//
// Bench for regfile_context_sequencer. A behavioural register file and memory
// responder surround the DUT; expected transfer lists, final register
// contents and operation lengths are derived from the operation rules.
// Honors CTX_SWAP_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_regfile_context_sequencer;
    localparam int FIRST = 1;
    localparam int LAST  = 31;
    localparam int COUNT = LAST - FIRST + 1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ctx_req = 1'b0;
    logic [1:0]  ctx_op = 2'b00;
    logic [31:0] save_base = 32'd0;
    logic [31:0] restore_base = 32'd0;
    logic        stall, busy, done;

    regfile_context_sequencer_if bus();

    regfile_context_sequencer #(.FIRST_REG(FIRST), .LAST_REG(LAST)) dut (
        .clk          (clk),
        .reset        (reset),
        .ctx_req      (ctx_req),
        .ctx_op       (ctx_op),
        .save_base    (save_base),
        .restore_base (restore_base),
        .bus          (bus.master),
        .stall        (stall),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } tx_t;

    tx_t         tx_q[$];
    tx_t         exp_q[$];
    logic [31:0] rf[32];
    logic [31:0] exp_rf[32];
    logic [31:0] mem[logic [31:0]];
    int          n_cmp = 0;
    int          n_fail = 0;
    int          done_cnt = 0;
    int          busy_cycles = 0;
    int          wr_cnt = 0;
    int          ack_min = 0;
    int          ack_max = 0;

    assign bus.rf_rd_data = rf[bus.rf_rd_addr];

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return 32'hBAD0_0000 ^ a;
    endfunction

    function automatic logic [111:0] outs_vec();
        return {stall, busy, done, bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata,
                bus.rf_rd_addr, bus.rf_wr_en, bus.rf_wr_addr, bus.rf_wr_data};
    endfunction

    // Environment: register-file write port, memory responder and monitors.
    initial begin
        logic waiting;
        int   wait_left;
        tx_t  hold;
        waiting = 1'b0;
        wait_left = 0;
        hold = '0;
        bus.mem_ack = 1'b0;
        bus.mem_rdata = 32'd0;
        for (int r = 0; r < 32; r++) rf[r] = 32'd0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                bus.mem_ack = 1'b0;
                waiting = 1'b0;
            end else begin
                if (busy) busy_cycles++;
                if (done) done_cnt++;
                if (bus.rf_wr_en) begin
                    n_cmp++;
                    if (bus.rf_wr_addr == 5'd0) begin
                        n_fail++;
                        $display("FAIL rf_wr_addr_nonzero: got addr=%0d, want nonzero", bus.rf_wr_addr);
                    end
                    if (bus.rf_wr_addr != 5'd0) rf[bus.rf_wr_addr] = bus.rf_wr_data;
                    wr_cnt++;
                end
                if (bus.mem_ack) begin
                    if (!hold.we) hold.data = bus.mem_rdata;
                    tx_q.push_back(hold);
                    bus.mem_ack = 1'b0;
                    waiting = 1'b0;
                end
                if (waiting) begin
                    n_cmp++;
                    if (!bus.mem_req || bus.mem_addr !== hold.addr || bus.mem_we !== hold.we ||
                        (hold.we && bus.mem_wdata !== hold.data)) begin
                        n_fail++;
                        $display("FAIL mem_hold: got req=%0b we=%0b addr=%h wdata=%h, want req=1 we=%0b addr=%h wdata=%h",
                                 bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata,
                                 hold.we, hold.addr, hold.data);
                    end
                end else if (bus.mem_req) begin
                    waiting = 1'b1;
                    hold.we = bus.mem_we;
                    hold.addr = bus.mem_addr;
                    hold.data = bus.mem_wdata;
                    wait_left = $urandom_range(ack_max, ack_min);
                end
                if (waiting) begin
                    if (wait_left == 0) begin
                        bus.mem_ack = 1'b1;
                        bus.mem_rdata = hold.we ? 32'd0 : mem_rd(hold.addr);
                    end else begin
                        wait_left--;
                    end
                end
            end
        end
    end

    function automatic void build_expected(input logic [1:0] op, input logic [31:0] sb, input logic [31:0] rb);
        tx_t t;
        exp_q.delete();
        for (int r = 0; r < 32; r++) exp_rf[r] = rf[r];
        if (op[0]) begin
            for (int i = FIRST; i <= LAST; i++) begin
                t.we = 1'b1;
                t.addr = sb + 32'(4 * i);
                t.data = rf[i];
                exp_q.push_back(t);
            end
        end
        if (op[1]) begin
            for (int i = FIRST; i <= LAST; i++) begin
                t.we = 1'b0;
                t.addr = rb + 32'(4 * i);
                t.data = mem_rd(t.addr);
                exp_q.push_back(t);
                exp_rf[i] = t.data;
            end
        end
    endfunction

    task automatic start_op(input logic [1:0] op, input logic [31:0] sb, input logic [31:0] rb);
        @(negedge clk); #1;
        busy_cycles = 0;
        done_cnt = 0;
        wr_cnt = 0;
        tx_q.delete();
        ctx_req = 1'b1;
        ctx_op = op;
        save_base = sb;
        restore_base = rb;
        @(negedge clk); #1;
        // Scramble the bases so a design that fails to latch them is exposed.
        ctx_req = 1'b0;
        ctx_op = 2'b00;
        save_base = $urandom;
        restore_base = $urandom;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            if (done_cnt > 0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk); #1;
        end
        if (done_cnt > 0) ok = 1'b1;
    endtask

    task automatic do_xfer(input logic [1:0] op, input logic [31:0] sb, input logic [31:0] rb,
                           output int cycles, output bit finished, output int tx_bad,
                           output int rf_bad, output logic busy_after);
        int n;
        build_expected(op, sb, rb);
        start_op(op, sb, rb);
        wait_done(4000, finished);
        cycles = busy_cycles;
        @(negedge clk); #1;
        busy_after = busy;
        n = (tx_q.size() < exp_q.size()) ? tx_q.size() : exp_q.size();
        tx_bad = (tx_q.size() > exp_q.size()) ? tx_q.size() - exp_q.size() : exp_q.size() - tx_q.size();
        for (int i = 0; i < n; i++) if (tx_q[i] !== exp_q[i]) tx_bad++;
        rf_bad = 0;
        for (int r = 0; r < 32; r++) if (rf[r] !== exp_rf[r]) rf_bad++;
    endtask

    task automatic test_reset();
        #1 reset = 1'b0;
        #2;
        n_cmp++;
        if (outs_vec() !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h, want 0", outs_vec());
        end
        @(negedge clk); #1 reset = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        n_cmp++;
        if (outs_vec() !== '0) begin
            n_fail++;
            $display("FAIL idle_outputs: got %h, want 0", outs_vec());
        end
    endtask

    task automatic test_save();
        int cyc, txb, rfb; bit fin; logic ba;
        rf[0] = 32'd0;
        for (int i = 1; i < 32; i++) rf[i] = 32'h100 + 32'(i);
        ack_min = 0; ack_max = 0;
        do_xfer(2'b01, 32'h1000, 32'h0, cyc, fin, txb, rfb, ba);
        n_cmp++; if (fin !== 1'b1) begin n_fail++; $display("FAIL save_done: got %0b, want 1", fin); end
        n_cmp++; if (cyc !== 2 * COUNT + 1) begin n_fail++; $display("FAIL save_latency: got %0d, want %0d", cyc, 2 * COUNT + 1); end
        n_cmp++; if (tx_q.size() !== COUNT) begin n_fail++; $display("FAIL save_count: got %0d, want %0d", tx_q.size(), COUNT); end
        n_cmp++; if (txb !== 0) begin n_fail++; $display("FAIL save_writes: got %0d bad, want 0", txb); end
        n_cmp++; if (wr_cnt !== 0 || rfb !== 0) begin n_fail++; $display("FAIL save_rf_untouched: got wr=%0d bad=%0d, want 0/0", wr_cnt, rfb); end
        n_cmp++; if (ba !== 1'b0) begin n_fail++; $display("FAIL save_idle_after: got busy=%0b, want 0", ba); end
    endtask

    task automatic test_restore();
        int cyc, txb, rfb; bit fin; logic ba;
        for (int i = 0; i < 32; i++) mem[32'h2000 + 32'(4 * i)] = 32'hA000_0000 + 32'(i);
        ack_min = 3; ack_max = 3;
        do_xfer(2'b10, 32'h0, 32'h2000, cyc, fin, txb, rfb, ba);
        n_cmp++; if (fin !== 1'b1) begin n_fail++; $display("FAIL restore_done: got %0b, want 1", fin); end
        n_cmp++; if (cyc !== COUNT * 5 + 1) begin n_fail++; $display("FAIL restore_latency: got %0d, want %0d", cyc, COUNT * 5 + 1); end
        n_cmp++; if (txb !== 0) begin n_fail++; $display("FAIL restore_reads: got %0d bad, want 0", txb); end
        n_cmp++; if (rfb !== 0) begin n_fail++; $display("FAIL restore_regs: got %0d bad, want 0", rfb); end
        n_cmp++; if (rf[0] !== 32'd0) begin n_fail++; $display("FAIL restore_x0: got %h, want 0", rf[0]); end
        n_cmp++; if (rf[31] !== 32'hA000_001F) begin n_fail++; $display("FAIL restore_x31: got %h, want a000001f", rf[31]); end
        ack_min = 0; ack_max = 0;
    endtask

    task automatic test_swap();
        for (int i = 1; i < 32; i++) rf[i] = $urandom;
        for (int i = 0; i < 32; i++) mem[32'h2000 + 32'(4 * i)] = $urandom;
        ack_min = 0; ack_max = 0;
`ifdef CTX_SWAP_EN
        begin
            int cyc, txb, rfb; bit fin; logic ba;
            do_xfer(2'b11, 32'h1000, 32'h2000, cyc, fin, txb, rfb, ba);
            n_cmp++; if (fin !== 1'b1) begin n_fail++; $display("FAIL swap_done: got %0b, want 1", fin); end
            n_cmp++; if (cyc !== 4 * COUNT + 1) begin n_fail++; $display("FAIL swap_latency: got %0d, want %0d", cyc, 4 * COUNT + 1); end
            n_cmp++; if (txb !== 0) begin n_fail++; $display("FAIL swap_order: got %0d bad, want 0", txb); end
            n_cmp++; if (rfb !== 0) begin n_fail++; $display("FAIL swap_regs: got %0d bad, want 0", rfb); end
        end
`else
        begin
            int rfb;
            build_expected(2'b00, 32'h0, 32'h0);
            start_op(2'b11, 32'h1000, 32'h2000);
            repeat (20) @(negedge clk);
            #1;
            rfb = 0;
            for (int r = 0; r < 32; r++) if (rf[r] !== exp_rf[r]) rfb++;
            n_cmp++; if (busy_cycles !== 0 || busy !== 1'b0) begin n_fail++; $display("FAIL swap_disabled_busy: got %0d busy cycles, want 0", busy_cycles); end
            n_cmp++; if (tx_q.size() !== 0 || wr_cnt !== 0 || rfb !== 0) begin n_fail++; $display("FAIL swap_disabled_xfer: got tx=%0d wr=%0d bad=%0d, want 0", tx_q.size(), wr_cnt, rfb); end
        end
`endif
    endtask

    task automatic test_ignore();
        int cyc, txb, rfb; bit fin; logic ba;
        @(negedge clk); #1;
        ctx_req = 1'b1; ctx_op = 2'b00;
        @(negedge clk); #1;
        ctx_req = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL noop_ignored: got busy=%0b, want 0", busy); end
        for (int i = 1; i < 32; i++) rf[i] = $urandom;
        fork
            do_xfer(2'b01, 32'h0000_4000, 32'h0, cyc, fin, txb, rfb, ba);
            begin
                repeat (12) @(negedge clk);
                #2;
                ctx_req = 1'b1; ctx_op = 2'b10; restore_base = 32'h2000;
                @(negedge clk); #2;
                ctx_req = 1'b0; ctx_op = 2'b00;
            end
        join
        n_cmp++; if (cyc !== 2 * COUNT + 1) begin n_fail++; $display("FAIL ignore_latency: got %0d, want %0d", cyc, 2 * COUNT + 1); end
        n_cmp++; if (txb !== 0) begin n_fail++; $display("FAIL ignore_writes: got %0d bad, want 0", txb); end
        n_cmp++; if (wr_cnt !== 0 || rfb !== 0) begin n_fail++; $display("FAIL ignore_rf: got wr=%0d bad=%0d, want 0/0", wr_cnt, rfb); end
    endtask

    task automatic test_random();
        int cyc, txb, rfb, d, nops, want; bit fin; logic ba;
        logic [1:0] op; logic [31:0] sb, rb;
        for (int it = 0; it < 6; it++) begin
`ifdef CTX_SWAP_EN
            op = 2'($urandom_range(3, 1));
`else
            op = 2'($urandom_range(2, 1));
`endif
            d = $urandom_range(2, 0);
            ack_min = d; ack_max = d;
            sb = {$urandom, 2'b00};
            rb = {$urandom, 2'b00};
            // First pass straddles the top of the address space.
            if (it == 0) begin sb = 32'hFFFF_FF80; rb = 32'hFFFF_FFC0; end
            for (int i = 1; i < 32; i++) rf[i] = $urandom;
            for (int i = FIRST; i <= LAST; i++) mem[rb + 32'(4 * i)] = $urandom;
            nops = (op == 2'b11) ? 2 : 1;
            want = nops * COUNT * (2 + d) + 1;
            do_xfer(op, sb, rb, cyc, fin, txb, rfb, ba);
            n_cmp++; if (fin !== 1'b1 || cyc !== want) begin n_fail++; $display("FAIL rand_latency[%0d]: got done=%0b cycles=%0d, want 1/%0d", it, fin, cyc, want); end
            n_cmp++; if (txb !== 0) begin n_fail++; $display("FAIL rand_xfers[%0d]: got %0d bad, want 0", it, txb); end
            n_cmp++; if (rfb !== 0) begin n_fail++; $display("FAIL rand_regs[%0d]: got %0d bad, want 0", it, rfb); end
        end
        ack_min = 0; ack_max = 0;
    endtask

    task automatic test_reset_mid();
        logic [31:0] old_rf[32];
        logic [31:0] rb;
        int  rfb, cyc, txb; bit fin, found; logic ba;
        rb = 32'h3000;
        for (int i = 1; i < 32; i++) rf[i] = $urandom;
        for (int r = 0; r < 32; r++) old_rf[r] = rf[r];
        for (int i = 0; i < 32; i++) mem[rb + 32'(4 * i)] = $urandom;
        ack_min = 2; ack_max = 2;
        start_op(2'b10, 32'h0, rb);
        found = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (bus.mem_req === 1'b1 && bus.mem_we === 1'b0 && bus.mem_addr === rb + 32'd28) begin
                found = 1'b1;
                break;
            end
            @(negedge clk); #1;
        end
        n_cmp++; if (found !== 1'b1) begin n_fail++; $display("FAIL midreset_reach_x7: got %0b, want 1", found); end
        #1 reset = 1'b0;
        #1;
        n_cmp++; if (outs_vec() !== '0) begin n_fail++; $display("FAIL midreset_async: got %h, want 0", outs_vec()); end
        repeat (3) @(negedge clk);
        #1 reset = 1'b1;
        repeat (6) @(negedge clk);
        #1;
        rfb = 0;
        for (int r = 0; r < 32; r++) begin
            if (r >= 1 && r <= 6) begin
                if (rf[r] !== mem[rb + 32'(4 * r)]) rfb++;
            end else if (rf[r] !== old_rf[r]) begin
                rfb++;
            end
        end
        n_cmp++; if (rfb !== 0) begin n_fail++; $display("FAIL midreset_regs: got %0d bad, want 0", rfb); end
        n_cmp++; if (done_cnt !== 0 || busy !== 1'b0) begin n_fail++; $display("FAIL midreset_no_done: got done=%0d busy=%0b, want 0/0", done_cnt, busy); end
        for (int i = 0; i < 32; i++) mem[rb + 32'(4 * i)] = $urandom;
        ack_min = 0; ack_max = 0;
        do_xfer(2'b10, 32'h0, rb, cyc, fin, txb, rfb, ba);
        n_cmp++; if (fin !== 1'b1 || cyc !== 2 * COUNT + 1) begin n_fail++; $display("FAIL midreset_rerun_latency: got done=%0b cycles=%0d, want 1/%0d", fin, cyc, 2 * COUNT + 1); end
        n_cmp++; if (txb !== 0 || rfb !== 0) begin n_fail++; $display("FAIL midreset_rerun: got tx=%0d regs=%0d bad, want 0/0", txb, rfb); end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_save();
        test_restore();
        test_swap();
        test_ignore();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
